// File: rtl/mul_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle 32x32 multiply sequencer:
// op codes, controller states and partial-product scheduling helpers.
package mul_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FIX   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Shift applied to a partial product, in units of the cell width.
    typedef enum logic [1:0] {
        SH_NONE = 2'd0,
        SH_HALF = 2'd1,
        SH_FULL = 2'd2
    } shift_e;

    localparam logic [1:0] PP0 = 2'd0;  // aL*bL
    localparam logic [1:0] PP1 = 2'd1;  // aH*bL
    localparam logic [1:0] PP2 = 2'd2;  // aL*bH
    localparam logic [1:0] PP3 = 2'd3;  // aH*bH

    function automatic shift_e pp_shift(input logic [1:0] idx);
        shift_e sh;
        case (idx)
            PP0:     sh = SH_NONE;
            PP1:     sh = SH_HALF;
            PP2:     sh = SH_HALF;
            default: sh = SH_FULL;
        endcase
        return sh;
    endfunction

    // The low word never depends on aH*bH, so MUL stops after three products.
    function automatic logic [2:0] pp_count(input op_e op);
        return (op == OP_MUL) ? 3'd3 : 3'd4;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_mul16_reg.sv
// HALF_W x HALF_W unsigned multiplier cell with MUL_LAT output registers,
// written so synthesis maps it onto a single DSP block.
module mul16_reg #(
    parameter int HALF_W  = 16,
    parameter int MUL_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [HALF_W-1:0]     a_i,
    input  logic [HALF_W-1:0]     b_i,
    output logic [2*HALF_W-1:0]   p_o
);

    localparam int PW = 2 * HALF_W;

    logic [PW-1:0] pipe_q [MUL_LAT];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= PW'(a_i) * PW'(b_i);
            for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign p_o = pipe_q[MUL_LAT-1];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 32x32 multiply sequencer: four 16x16 partial products through
// one shared cell, accumulated to 64 bits, then sign-corrected per op.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int HALF_W  = 16,
    parameter int MUL_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [2*HALF_W-1:0]   src1,
    input  logic [2*HALF_W-1:0]   src2,
    output logic                  busy,
    output logic                  done,
    output logic [2*HALF_W-1:0]   result
);

    localparam int DATA_W = 2 * HALF_W;
    localparam int ACC_W  = 2 * DATA_W;

    state_e              state_q;
    op_e                 op_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [1:0]          idx_q;
    logic [7:0]          drain_q;
    logic [ACC_W-1:0]    acc_q;
    logic [DATA_W-1:0]   result_q;
    logic                busy_q, done_q;

    logic                vld_q [MUL_LAT];
    shift_e              sh_q  [MUL_LAT];

    logic [HALF_W-1:0]   mul_a_d, mul_b_d;
    logic [DATA_W-1:0]   prod;
    logic                issue_d, last_issue_d;
    shift_e              sh_d;
    logic [ACC_W-1:0]    pp_ext_d, acc_d;
    logic [DATA_W-1:0]   hi_corr_d, res_d;
    logic                s1_neg_d, s2_neg_d;

    mul16_reg #(
        .HALF_W  (HALF_W),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .a_i     (mul_a_d),
        .b_i     (mul_b_d),
        .p_o     (prod)
    );

    always_comb begin
        issue_d      = (state_q == ST_ISSUE);
        last_issue_d = ({1'b0, idx_q} == (pp_count(op_q) - 3'd1));
        sh_d         = pp_shift(idx_q);
        mul_a_d      = idx_q[0] ? a_q[DATA_W-1:HALF_W] : a_q[HALF_W-1:0];
        mul_b_d      = idx_q[1] ? b_q[DATA_W-1:HALF_W] : b_q[HALF_W-1:0];

        pp_ext_d = ACC_W'(prod);
        case (sh_q[MUL_LAT-1])
            SH_NONE: pp_ext_d = ACC_W'(prod);
            SH_HALF: pp_ext_d = ACC_W'(prod) << HALF_W;
            default: pp_ext_d = ACC_W'(prod) << DATA_W;
        endcase
        acc_d = vld_q[MUL_LAT-1] ? (acc_q + pp_ext_d) : acc_q;

        // Subtracting x<<DATA_W modulo 2^ACC_W only touches the high word.
        s1_neg_d  = ((op_q == OP_MULXSU) || (op_q == OP_MULXSS)) && a_q[DATA_W-1];
        s2_neg_d  = (op_q == OP_MULXSS) && b_q[DATA_W-1];
        hi_corr_d = acc_q[ACC_W-1:DATA_W]
                    - (s1_neg_d ? b_q : '0)
                    - (s2_neg_d ? a_q : '0);
        res_d     = (op_q == OP_MUL) ? acc_q[DATA_W-1:0] : hi_corr_d;
    end

    // Valid/shift tags mirror the multiplier's register stages.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < MUL_LAT; i++) vld_q[i] <= 1'b0;
        end else begin
            vld_q[0] <= issue_d;
            for (int i = 1; i < MUL_LAT; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        sh_q[0] <= sh_d;
        for (int i = 1; i < MUL_LAT; i++) sh_q[i] <= sh_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            acc_q    <= '0;
            idx_q    <= PP0;
            drain_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= src1;
                        b_q     <= src2;
                        op_q    <= op_e'(op);
                        acc_q   <= '0;
                        idx_q   <= PP0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 2'd1;
                    if (last_issue_d) begin
                        drain_q <= 8'(MUL_LAT - 1);
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    acc_q <= acc_d;
                    if (drain_q == 8'd0) state_q <= ST_FIX;
                    else                 drain_q <= drain_q - 8'd1;
                end
                ST_FIX: begin
                    result_q <= res_d;
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: expected result and done latency are
// queued at acceptance and checked by a monitor when done pulses.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1, src2;
    logic        busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    mul_seq_ctrl #(.HALF_W(16), .MUL_LAT(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .src1    (src1),
        .src2    (src2),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sbv, p;
        sa  = o[1]        ? $signed({{32{a[31]}}, a}) : $signed({32'b0, a});
        sbv = (o == 2'b11) ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
        p   = sa * sbv;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Done monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: result=%h with nothing outstanding (cycle %0d)",
                         result, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (result !== mon_e.res || (cyc - mon_e.acc_cyc) != mon_e.lat) begin
                    fails++;
                    $display("FAIL done_check: result=%h latency=%0d, want result=%h latency=%0d",
                             result, cyc - mon_e.acc_cyc, mon_e.res, mon_e.lat);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] r, input logic [1:0] o);
        exp_t e;
        e.res     = r;
        e.acc_cyc = cyc;
        e.lat     = (o == 2'b00) ? 6 : 7;
        sb.push_back(e);
    endtask

    // Called just after a rising edge with the DUT idle; returns in cycle 1.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input bit do_push);
        op = o; src1 = a; src2 = b; start = 1'b1;
        if (do_push) push_exp(r, o);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_cycle0: busy=%b want 0", busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        src1 = $urandom; src2 = $urandom; op = 2'($urandom);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_cycle1: busy=%b want 1", busy);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (sb.size() != 0 && n < 60);
        #1;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d results outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests += 3;
        if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: busy=%b want 0", busy); end
        if (done !== 1'b0)    begin fails++; $display("FAIL reset_done: done=%b want 0", done); end
        if (result !== 32'h0) begin fails++; $display("FAIL reset_result: result=%h want 0", result); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        start_op(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b1); wait_drain();
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1); wait_drain();
        start_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_drain();
        start_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1); wait_drain();
        start_op(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1); wait_drain();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [1:0]  o;
        for (int i = 0; i < 24; i++) begin
            o = 2'(i % 4);
            case (i / 4)
                0: begin a = 32'h8000_0000; b = 32'h7FFF_FFFF; end
                1: begin a = 32'h0000_0000; b = $urandom; end
                2: begin a = 32'h7FFF_FFFF; b = 32'hFFFF_FFFF; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            start_op(o, a, b, model(o, a, b), 1'b1);
            wait_drain();
        end
    endtask

    task automatic test_hold_start();
        op = 2'b01; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0; start = 1'b1;
        push_exp(model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0), 2'b01);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            op = 2'($urandom); src1 = $urandom; src2 = $urandom;
            @(negedge clk);
            tests++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL hold_busy: cycle %0d busy=%b want 1", k, busy);
            end
        end
        @(posedge clk); #1;
        op = 2'b00; src1 = 32'd9; src2 = 32'd11;
        push_exp(32'd99, 2'b00);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_idle_gap: busy=%b want 0", busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL hold_reaccept: busy=%b want 1", busy);
        end
        wait_drain();
    endtask

    task automatic test_reset_abort();
        start_op(2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        tests += 3;
        if (busy !== 1'b0)    begin fails++; $display("FAIL abort_busy: busy=%b want 0", busy); end
        if (done !== 1'b0)    begin fails++; $display("FAIL abort_done: done=%b want 0", done); end
        if (result !== 32'h0) begin fails++; $display("FAIL abort_result: result=%h want 0", result); end
        repeat (10) @(posedge clk);
        #1;
        start_op(2'b00, 32'd3, 32'd5, 32'h0000_000F, 1'b1);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_hold_start();
        test_reset_abort();
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
